// File: rtl/tx_queue_serializer.sv
// tx_queue_serializer: circular FIFO feeding an LSB-first serializer with optional framing and inter-word gap
module tx_queue_serializer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int FRAME  = 0,
  parameter int GAP    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          datain,
  input  logic                       en,
  output logic                       txd,
  output logic                       tbusy,
  output logic                       tfin,
  output logic                       tbnfout,
  output logic                       tbeout,
  output logic [$clog2(DEPTH+1)-1:0] countout,
  output logic                       ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP + 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, tfin_q, tfin_d;
  logic              pop, push;
  assign push     = en && (count_q != CW'(DEPTH) || pop);
  assign wr_d     = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
  assign rd_d     = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign ovf_d    = ovf_q | (en & ~push);
  assign txd      = state_q == DATA ? sr_q[0] : state_q != START;
  assign tbusy    = state_q != IDLE;
  assign tfin     = tfin_q;
  assign tbnfout  = count_q != CW'(DEPTH);
  assign tbeout   = count_q == '0;
  assign countout = count_q;
  assign ovf      = ovf_q;
  // transmit sequencing: launch from the FIFO head, shift, frame, then restart the gap
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    gap_d   = (state_q == IDLE && gap_q != GW'(GAP)) ? gap_q + GW'(1) : gap_q;
    tfin_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0 && gap_q == GW'(GAP)) begin
        pop     = 1'b1;
        sr_d    = mem_q[rd_q];
        bit_d   = '0;
        state_d = FRAME != 0 ? START : DATA;
      end
      START: state_d = DATA;
      DATA: begin
        sr_d  = sr_q >> 1;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DATA_W - 1)) begin
          state_d = FRAME != 0 ? STOP : IDLE;
          tfin_d  = FRAME == 0;
          gap_d   = FRAME != 0 ? gap_q : '0;
        end
      end
      default: begin
        state_d = IDLE;
        tfin_d  = 1'b1;
        gap_d   = '0;
      end
    endcase
  end
  // control and queue state; reset aborts any word and flushes the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      gap_q   <= GW'(GAP);
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      tfin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      tfin_q  <= tfin_d;
    end
  end
  // FIFO storage needs no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= datain;
  end
endmodule
